// File: rtl/wb_async_mem_master.sv
// Wishbone classic slave to async SRAM-style master; ack T_SETUP+T_STROBE+T_HOLD+1 edges after accept.
// One request at a time; a new request is taken only from IDLE, and mem_wait_n_i stretches STROBE up to TIMEOUT cycles.
module wb_async_mem_master #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [DW-1:0] mem_dat_o,
  input  logic [DW-1:0] mem_dat_i,
  output logic          mem_dat_oe_o,
  output logic          mem_ce_n_o,
  output logic          mem_we_n_o,
  output logic          mem_oe_n_o,
  output logic [3:0]    mem_be_n_o,
  input  logic          mem_wait_n_i
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [3:0]     SETUP_LAST  = 4'(T_SETUP - 1);
  localparam logic [3:0]     STROBE_LAST = 4'(T_STROBE - 1);
  localparam logic [3:0]     HOLD_LAST   = 4'(T_HOLD - 1);
  localparam logic [WCW-1:0] WAIT_MAX    = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_ONE    = WCW'(1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [WCW-1:0] wait_q, wait_d;
  req_t           req_q, req_d;
  logic           abort_q, abort_d;
  logic           tout_q, tout_d;
  logic           ce_n_q, ce_n_d;
  logic           we_n_q, we_n_d;
  logic           oe_n_q, oe_n_d;
  logic [3:0]     be_n_q, be_n_d;
  logic           dat_oe_q, dat_oe_d;
  logic [DW-1:0]  rdat_q, rdat_d;
  logic           ack_q, ack_d;
  logic           err_q, err_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    req_d    = req_q;
    abort_d  = abort_q;
    tout_d   = tout_q;
    ce_n_d   = ce_n_q;
    we_n_d   = we_n_q;
    oe_n_d   = oe_n_q;
    be_n_d   = be_n_q;
    dat_oe_d = dat_oe_q;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        wait_d  = '0;
        abort_d = 1'b0;
        tout_d  = 1'b0;
        if (wb_cyc_i && wb_stb_i) begin
          req_d.we  = wb_we_i;
          req_d.adr = wb_adr_i;
          req_d.dat = wb_dat_i;
          be_n_d    = ~wb_sel_i;
          ce_n_d    = 1'b0;
          dat_oe_d  = wb_we_i;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          we_n_d  = ~req_q.we;
          oe_n_d  = req_q.we;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STROBE: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        // Wait is only honoured once the minimum strobe width has elapsed.
        if (cnt_q != STROBE_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (mem_wait_n_i || (wait_q == WAIT_MAX)) begin
          cnt_d   = '0;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = HOLD;
          if (!mem_wait_n_i) tout_d = 1'b1;
          else if (!req_q.we) rdat_d = mem_dat_i;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      HOLD: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          cnt_d    = '0;
          ce_n_d   = 1'b1;
          dat_oe_d = 1'b0;
          be_n_d   = 4'hF;
          state_d  = DONE;
          // A master that walked away mid-cycle gets no termination.
          if (wb_cyc_i && !abort_q) begin
            ack_d = ~tout_q;
            err_d = tout_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      req_q    <= '0;
      abort_q  <= 1'b0;
      tout_q   <= 1'b0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      be_n_q   <= 4'hF;
      dat_oe_q <= 1'b0;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      abort_q  <= abort_d;
      tout_q   <= tout_d;
      ce_n_q   <= ce_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      be_n_q   <= be_n_d;
      dat_oe_q <= dat_oe_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign wb_dat_o     = rdat_q;
  assign wb_ack_o     = ack_q;
  assign wb_err_o     = err_q;
  assign mem_adr_o    = req_q.adr;
  assign mem_dat_o    = req_q.dat;
  assign mem_dat_oe_o = dat_oe_q;
  assign mem_ce_n_o   = ce_n_q;
  assign mem_we_n_o   = we_n_q;
  assign mem_oe_n_o   = oe_n_q;
  assign mem_be_n_o   = be_n_q;

endmodule

// File: tb/tb_wb_async_mem_master.sv
// Directed bench for wb_async_mem_master with a 16-word async memory model on mem_adr_o[5:2].
module tb_wb_async_mem_master;

  logic        clk = 1'b0;
  logic        wb_rst_n_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;
  logic        mem_dat_oe_o, mem_ce_n_o, mem_we_n_o, mem_oe_n_o;
  logic [3:0]  mem_be_n_o;
  logic        mem_wait_n_i;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_async_mem_master dut (
    .wb_clk_i(clk), .wb_rst_n_i(wb_rst_n_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i),
    .mem_dat_oe_o(mem_dat_oe_o), .mem_ce_n_o(mem_ce_n_o), .mem_we_n_o(mem_we_n_o),
    .mem_oe_n_o(mem_oe_n_o), .mem_be_n_o(mem_be_n_o), .mem_wait_n_i(mem_wait_n_i)
  );

  // Memory model
  logic [31:0] mem [0:15];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  assign mem_dat_i = (mem_ce_n_o === 1'b0 && mem_oe_n_o === 1'b0) ? mem[mem_adr_o[5:2]] : 32'h0BAD_F00D;
  always @(posedge clk) begin
    if (mem_ce_n_o === 1'b0 && mem_we_n_o === 1'b0)
      for (int b = 0; b < 4; b++)
        if (!mem_be_n_o[b]) mem[mem_adr_o[5:2]][b*8 +: 8] <= mem_dat_o[b*8 +: 8];
  end

  // Bus monitors
  int ack_cnt = 0, err_cnt = 0, both_cnt = 0, ack_run = 0, max_ack_run = 0;
  int ce_fall = 0, term_with_ce = 0;
  logic prev_ce_n = 1'b1;
  always @(negedge clk) begin
    if (wb_ack_o === 1'b1) ack_cnt++;
    if (wb_err_o === 1'b1) err_cnt++;
    if (wb_ack_o === 1'b1 && wb_err_o === 1'b1) both_cnt++;
    if ((wb_ack_o === 1'b1 || wb_err_o === 1'b1) && mem_ce_n_o !== 1'b1) term_with_ce++;
    if (wb_ack_o === 1'b1) ack_run++; else ack_run = 0;
    if (ack_run > max_ack_run) max_ack_run = ack_run;
    if (prev_ce_n === 1'b1 && mem_ce_n_o === 1'b0) ce_fall++;
    prev_ce_n = mem_ce_n_o;
  end

  // Runs one transfer starting just after a rising edge; wait_n is pulled low on strobe cycles [wfrom, wfrom+wlen).
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input int wfrom, input int wlen,
                      output int edges, output int we_low, output int oe_low, output logic [3:0] be_seen,
                      output logic oe_seen, output logic [31:0] rdata, output logic got_err);
    int  sidx;
    bit  done;
    edges = -1; we_low = 0; oe_low = 0; be_seen = 4'hx; oe_seen = 1'bx;
    rdata = 32'hx; got_err = 1'b0; sidx = 0; done = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    @(posedge clk);
    for (int n = 1; n <= 400 && !done; n++) begin
      @(negedge clk);
      if (mem_we_n_o === 1'b0 || mem_oe_n_o === 1'b0) begin
        sidx++;
        be_seen = mem_be_n_o;
        oe_seen = mem_dat_oe_o;
        if (mem_we_n_o === 1'b0) we_low++;
        if (mem_oe_n_o === 1'b0) oe_low++;
        mem_wait_n_i = !(sidx >= wfrom && sidx < wfrom + wlen);
      end else begin
        mem_wait_n_i = 1'b1;
      end
      if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
        edges = n; got_err = wb_err_o; rdata = wb_dat_o; done = 1;
      end
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; mem_wait_n_i = 1'b1;
  endtask

  int e, wl, ol;
  logic [3:0] bs;
  logic os, ge;
  logic [31:0] rd;

  task automatic test_reset();
    wb_rst_n_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_ce_n_o, mem_we_n_o, mem_oe_n_o, mem_be_n_o, mem_dat_oe_o, wb_ack_o, wb_err_o} !== 10'b1111111000)
      $display("FAIL reset_ctrl: got %b want 1111111000",
               {mem_ce_n_o, mem_we_n_o, mem_oe_n_o, mem_be_n_o, mem_dat_oe_o, wb_ack_o, wb_err_o});
    else passed++;
    checks++;
    if (mem_adr_o !== 32'h0) $display("FAIL reset_adr: got %h want 0", mem_adr_o); else passed++;
    checks++;
    if (mem_dat_o !== 32'h0) $display("FAIL reset_mem_dat: got %h want 0", mem_dat_o); else passed++;
    checks++;
    if (wb_dat_o !== 32'h0) $display("FAIL reset_wb_dat: got %h want 0", wb_dat_o); else passed++;
    wb_rst_n_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    xfer(1'b1, 32'h8300_0000, 32'hABBA_BEEF, 4'hF, 0, 0, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (e !== 6 || ge !== 1'b0) $display("FAIL write_ack_edge: got %0d err %b want 6 err 0", e, ge); else passed++;
    checks++;
    if (wl !== 3 || ol !== 0) $display("FAIL write_strobe: got we_low %0d oe_low %0d want 3 0", wl, ol); else passed++;
    checks++;
    if (bs !== 4'h0 || os !== 1'b1) $display("FAIL write_be_oe: got be %h oe %b want 0 1", bs, os); else passed++;
    checks++;
    if (mem[0] !== 32'hABBA_BEEF) $display("FAIL write_mem: got %h want abbabeef", mem[0]); else passed++;
  endtask

  task automatic test_read();
    xfer(1'b0, 32'h8300_0000, 32'h0, 4'hF, 0, 0, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (e !== 6) $display("FAIL read_ack_edge: got %0d want 6", e); else passed++;
    checks++;
    if (ol !== 3 || wl !== 0 || os !== 1'b0)
      $display("FAIL read_strobe: got oe_low %0d we_low %0d dat_oe %b want 3 0 0", ol, wl, os);
    else passed++;
    checks++;
    if (rd !== 32'hABBA_BEEF) $display("FAIL read_data: got %h want abbabeef", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    int f0;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h5555_5555; exp_d[1] = 32'hAAAA_AAAA; exp_d[2] = 32'h5555_5555;
    f0 = ce_fall;
    for (int i = 0; i < 3; i++)
      xfer(1'b1, 32'h8300_0004 + 32'(i * 4), exp_d[i], 4'hF, 0, 0, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (ce_fall - f0 !== 3) $display("FAIL b2b_ce_gaps: got %0d ce falls want 3", ce_fall - f0); else passed++;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'h8300_0004 + 32'(i * 4), 32'h0, 4'hF, 0, 0, e, wl, ol, bs, os, rd, ge);
      checks++;
      if (rd !== exp_d[i] || e !== 6) $display("FAIL b2b_readback%0d: got %h edge %0d want %h edge 6", i, rd, e, exp_d[i]);
      else passed++;
    end
  endtask

  task automatic test_sel();
    xfer(1'b1, 32'h8300_0004, 32'h0000_0000, 4'h0, 0, 0, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (bs !== 4'hF || e !== 6 || wl !== 3)
      $display("FAIL sel_zero: got be %h edge %0d we_low %0d want f 6 3", bs, e, wl);
    else passed++;
    checks++;
    if (mem[1] !== 32'h5555_5555) $display("FAIL sel_zero_mem: got %h want 55555555", mem[1]); else passed++;
    xfer(1'b1, 32'h8300_0008, 32'h1234_5678, 4'b0101, 0, 0, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (bs !== 4'b1010) $display("FAIL sel_partial_be: got %b want 1010", bs); else passed++;
    checks++;
    if (mem[2] !== 32'hAA34_AA78) $display("FAIL sel_partial_mem: got %h want aa34aa78", mem[2]); else passed++;
  endtask

  task automatic test_wait();
    xfer(1'b0, 32'h8300_0000, 32'h0, 4'hF, 3, 5, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (ol !== 8) $display("FAIL wait_strobe_len: got %0d want 8", ol); else passed++;
    checks++;
    if (e !== 11 || ge !== 1'b0) $display("FAIL wait_ack_edge: got %0d err %b want 11 err 0", e, ge); else passed++;
    checks++;
    if (rd !== 32'hABBA_BEEF) $display("FAIL wait_data: got %h want abbabeef", rd); else passed++;
  endtask

  task automatic test_timeout();
    int a0;
    a0 = ack_cnt;
    xfer(1'b0, 32'h8300_000C, 32'h0, 4'hF, 1, 100000, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (e !== 261 || ge !== 1'b1) $display("FAIL timeout_err_edge: got %0d err %b want 261 err 1", e, ge); else passed++;
    checks++;
    if (ack_cnt !== a0) $display("FAIL timeout_no_ack: got %0d acks want 0", ack_cnt - a0); else passed++;
    checks++;
    if (ol !== 258) $display("FAIL timeout_strobe_len: got %0d want 258", ol); else passed++;
    checks++;
    if (wb_dat_o !== 32'hABBA_BEEF) $display("FAIL timeout_dat_kept: got %h want abbabeef", wb_dat_o); else passed++;
    checks++;
    if ({mem_ce_n_o, mem_we_n_o, mem_oe_n_o} !== 3'b111)
      $display("FAIL timeout_release: got %b want 111", {mem_ce_n_o, mem_we_n_o, mem_oe_n_o});
    else passed++;
  endtask

  task automatic test_cyc_drop();
    int a0, r0, wlow;
    a0 = ack_cnt; r0 = err_cnt; wlow = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h8300_0010; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_we_n_o === 1'b0) wlow++;
      if (n == 2) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
    end
    checks++;
    if (wlow !== 3) $display("FAIL cyc_drop_strobe: got %0d want 3", wlow); else passed++;
    checks++;
    if (ack_cnt !== a0 || err_cnt !== r0)
      $display("FAIL cyc_drop_no_term: got ack %0d err %0d want 0 0", ack_cnt - a0, err_cnt - r0);
    else passed++;
    checks++;
    if (mem[4] !== 32'hCAFE_F00D || mem_ce_n_o !== 1'b1)
      $display("FAIL cyc_drop_complete: got mem %h ce_n %b want cafef00d 1", mem[4], mem_ce_n_o);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int a0, r0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 32'h8300_0014; wb_dat_i = 32'h1111_2222; wb_sel_i = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_we_n_o !== 1'b0) $display("FAIL rst_mid_in_strobe: got we_n %b want 0", mem_we_n_o); else passed++;
    a0 = ack_cnt; r0 = err_cnt;
    wb_rst_n_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_ce_n_o, mem_we_n_o, mem_oe_n_o, mem_dat_oe_o, wb_ack_o} !== 5'b11100)
      $display("FAIL rst_mid_release: got %b want 11100", {mem_ce_n_o, mem_we_n_o, mem_oe_n_o, mem_dat_oe_o, wb_ack_o});
    else passed++;
    wb_rst_n_i = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (ack_cnt !== a0 || err_cnt !== r0)
      $display("FAIL rst_mid_no_term: got ack %0d err %0d want 0 0", ack_cnt - a0, err_cnt - r0);
    else passed++;
    xfer(1'b0, 32'h8300_0000, 32'h0, 4'hF, 0, 0, e, wl, ol, bs, os, rd, ge);
    checks++;
    if (rd !== 32'hABBA_BEEF || e !== 6) $display("FAIL rst_mid_recover: got %h edge %0d want abbabeef 6", rd, e);
    else passed++;
  endtask

  task automatic test_term_rules();
    checks++;
    if (both_cnt !== 0) $display("FAIL ack_err_together: got %0d cycles want 0", both_cnt); else passed++;
    checks++;
    if (max_ack_run !== 1) $display("FAIL ack_width: got %0d want 1", max_ack_run); else passed++;
    checks++;
    if (term_with_ce !== 0) $display("FAIL term_outside_done: got %0d cycles want 0", term_with_ce); else passed++;
  endtask

  initial begin
    wb_rst_n_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0; mem_wait_n_i = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_sel();
    test_wait();
    test_timeout();
    test_cyc_drop();
    test_reset_mid();
    test_term_rules();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
